// File: rtl/alu_compare_if.sv
// alu_compare_if: request/response bundle between execute and the slice comparator
//  master: drives in_valid, operand_A, operand_B, op, out_ready
//  slave : drives in_ready, out_valid, Greater, Equal, Less, result
interface alu_compare_if #(parameter int DATA_WIDTH = 32);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] operand_A;
  logic [DATA_WIDTH-1:0] operand_B;
  logic [2:0]            op;
  logic                  out_valid;
  logic                  out_ready;
  logic                  Greater;
  logic                  Equal;
  logic                  Less;
  logic                  result;
  modport master (
    output in_valid, operand_A, operand_B, op, out_ready,
    input  in_ready, out_valid, Greater, Equal, Less, result
  );
  modport slave (
    input  in_valid, operand_A, operand_B, op, out_ready,
    output in_ready, out_valid, Greater, Equal, Less, result
  );
endinterface

// File: rtl/alu_compare_unit.sv
// alu_compare_unit: multi-cycle MSB-first slice comparator evaluating RV32IM branch/SLT funct3 conditions
//  clk, rst : clock, asynchronous active-high reset
//  bus      : alu_compare_if.slave (valid/ready request in, held result out)
module alu_compare_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  alu_compare_if.slave bus
);
  localparam int N  = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  if (DATA_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of CHUNK_WIDTH");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  a_q, a_d, b_q, b_d, a_sh, b_sh;
  logic [2:0]             op_q, op_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   gt_q, gt_d, eq_q, eq_d, lt_q, lt_d, res_q, res_d;
  logic [CHUNK_WIDTH-1:0] a_sl, b_sl;
  logic                   sgn, s_gt, s_lt, s_eq;
  // Shifting the current slice to the top keeps the select index constant.
  assign a_sh = a_q << (int'(idx_q) * CHUNK_WIDTH);
  assign b_sh = b_q << (int'(idx_q) * CHUNK_WIDTH);
  assign a_sl = a_sh[DATA_WIDTH-1 -: CHUNK_WIDTH];
  assign b_sl = b_sh[DATA_WIDTH-1 -: CHUNK_WIDTH];
  assign sgn  = op_q == 3'b010 || op_q == 3'b100 || op_q == 3'b101;
  // Only the MSB slice carries the sign; lower slices are plain magnitude.
  assign s_gt = (sgn && idx_q == '0) ? ($signed(a_sl) > $signed(b_sl)) : (a_sl > b_sl);
  assign s_lt = (sgn && idx_q == '0) ? ($signed(a_sl) < $signed(b_sl)) : (a_sl < b_sl);
  assign s_eq = a_sl == b_sl;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    idx_d   = idx_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        a_d     = bus.operand_A;
        b_d     = bus.operand_B;
        op_d    = bus.op;
        idx_d   = '0;
        state_d = BUSY;
      end
      BUSY: if (!s_eq || idx_q == LAST) begin
        gt_d    = s_gt;
        lt_d    = s_lt;
        eq_d    = s_eq;
        res_d   = op_q == 3'b000 ? s_eq : op_q == 3'b001 ? !s_eq : (op_q[2] && op_q[0]) ? !s_lt : s_lt;
        state_d = DONE;
      end else begin
        idx_d = idx_q + IW'(1);
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      res_q   <= res_d;
    end
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.Greater   = gt_q;
  assign bus.Equal     = eq_q;
  assign bus.Less      = lt_q;
  assign bus.result    = res_q;
endmodule

// File: tb/tb_alu_compare_unit.sv
// tb_alu_compare_unit: directed and randomized checks of alu_compare_unit against an arithmetic model
module tb_alu_compare_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic g, e, l, r;
  int   lat;
  alu_compare_if #(.DATA_WIDTH(32)) bus ();
  alu_compare_unit #(.DATA_WIDTH(32), .CHUNK_WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o,
                       output logic mg, output logic me, output logic ml, output logic mr, output int k);
    logic sg;
    sg = o == 3'b010 || o == 3'b100 || o == 3'b101;
    me = a == b;
    ml = sg ? ($signed(a) < $signed(b)) : (a < b);
    mg = !me && !ml;
    case (o)
      3'b000: mr = me;
      3'b001: mr = !me;
      3'b101, 3'b111: mr = !ml;
      default: mr = ml;
    endcase
    k = 3;
    for (int i = 0; i < 4; i++)
      if (a[31-8*i -: 8] != b[31-8*i -: 8]) begin
        k = i;
        break;
      end
  endtask
  task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o,
                     input int gap, input int hold, input bit pulse, input bit overlap,
                     output logic og, output logic oe, output logic ol, output logic orr, output int olat);
    logic mg, me, ml, mr;
    int   k, n;
    model(a, b, o, mg, me, ml, mr, k);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.operand_A = a;
    bus.operand_B = b;
    bus.op        = o;
    bus.in_valid  = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_idle", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    olat = 0;
    while (!bus.out_valid && olat < 20) begin
      @(posedge clk);
      #1 olat++;
    end
    og  = bus.Greater;
    oe  = bus.Equal;
    ol  = bus.Less;
    orr = bus.result;
    chk("latency", olat, k + 1);
    chk("Greater", og, mg);
    chk("Equal", oe, me);
    chk("Less", ol, ml);
    chk("result", orr, mr);
    chk("in_ready_busy", bus.in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid = pulse && i == 2;
      @(posedge clk);
      #1;
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_ready", bus.in_ready, 0);
      chk("hold_flags", {bus.Greater, bus.Equal, bus.Less, bus.result}, {og, oe, ol, orr});
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = overlap;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk("consumed", bus.out_valid, 0);
    chk("idle_after", bus.in_ready, 1);
  endtask
  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.operand_A = '0;
    bus.operand_B = '0;
    bus.op        = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_flags", {bus.Greater, bus.Equal, bus.Less, bus.result}, 4'b0000);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 chk("rst_in_ready", bus.in_ready, 1);
    txn(32'd5, 32'd3, 3'b100, 0, 0, 0, 0, g, e, l, r, lat);
    chk("t1", {g, e, l, r, 4'(lat)}, {4'b1000, 4'd4});
    txn(32'h8000_0000, 32'h1, 3'b100, 0, 0, 0, 0, g, e, l, r, lat);
    chk("t2_blt", {l, r, 4'(lat)}, {2'b11, 4'd1});
    txn(32'h8000_0000, 32'h1, 3'b110, 0, 0, 0, 0, g, e, l, r, lat);
    chk("t2_bltu", {g, r, 4'(lat)}, {2'b10, 4'd1});
    txn(32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b000, 0, 0, 0, 0, g, e, l, r, lat);
    chk("t3_beq", {e, r, 4'(lat)}, {2'b11, 4'd4});
    txn(32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b001, 0, 0, 0, 0, g, e, l, r, lat);
    chk("t3_bne", r, 0);
    txn(32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b101, 0, 0, 0, 0, g, e, l, r, lat);
    chk("t3_bge", r, 1);
    txn(32'h1234_5678, 32'h1234_0000, 3'b111, 1, 5, 1, 0, g, e, l, r, lat);
    repeat (3) begin
      @(posedge clk);
      #1 chk("no_ghost_accept", {bus.in_ready, bus.out_valid}, 2'b10);
    end
    txn(32'h7, 32'h9, 3'b011, 0, 1, 0, 1, g, e, l, r, lat);
    txn(32'h9, 32'h7, 3'b011, 0, 0, 0, 0, g, e, l, r, lat);
    @(negedge clk);
    bus.operand_A = 32'd5;
    bus.operand_B = 32'd3;
    bus.op        = 3'b100;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", bus.out_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1 chk("midrst_idle", {bus.in_ready, bus.out_valid}, 2'b10);
    end
    txn(32'hFFFF_FFFF, 32'h0, 3'b010, 0, 0, 0, 0, g, e, l, r, lat);
    chk("t5_slt", {r, 4'(lat)}, {1'b1, 4'd1});
    txn(32'hFFFF_FFFF, 32'h0, 3'b011, 0, 0, 0, 0, g, e, l, r, lat);
    chk("t5_sltu", r, 0);
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 2))
        0: b = $urandom;
        1: b = a ^ ($urandom & (32'hFFFF_FFFF >> (8 * $urandom_range(0, 3))));
        default: b = a;
      endcase
      txn(a, b, 3'($urandom_range(0, 7)), $urandom_range(0, 2), $urandom_range(0, 2),
          0, 0, g, e, l, r, lat);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
